// File: rtl/dflipflop_universal_register_if.sv
// Control, data and status bundle of the universal shift/load register.
// The master drives mode and data inputs; the slave (the register) returns Q and its status.
interface dflipflop_universal_register_if #(
    parameter int WIDTH = 4
);
    logic             input_switch3_en_3;
    logic [1:0]       input_switch4_mode_4;
    logic             input_switch5_rot_5;
    logic             input_switch6_sin_6;
    logic [WIDTH-1:0] input_switch7_d_7;
    logic [WIDTH-1:0] output_led1_q_8;
    logic [WIDTH-1:0] output_led2_qbar_9;
    logic             output_led3_sout_10;
    logic             output_led4_zero_11;

    modport master (
        output input_switch3_en_3, input_switch4_mode_4, input_switch5_rot_5,
               input_switch6_sin_6, input_switch7_d_7,
        input  output_led1_q_8, output_led2_qbar_9, output_led3_sout_10,
               output_led4_zero_11
    );

    modport slave (
        input  input_switch3_en_3, input_switch4_mode_4, input_switch5_rot_5,
               input_switch6_sin_6, input_switch7_d_7,
        output output_led1_q_8, output_led2_qbar_9, output_led3_sout_10,
               output_led4_zero_11
    );
endinterface

// File: rtl/dflipflop_universal_register.sv
// WIDTH-bit universal register: hold, shift right/left (serial fill or rotate), parallel load.
// One D flip-flop per bit; Qbar, sout and zero are decoded combinationally from Q.
module dflipflop_universal_register #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input logic                           input_clock1_clk_1,
    input logic                           input_push_button2_rst_2,
    dflipflop_universal_register_if.slave bus
);
    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [WIDTH-1:0] q_p0;
    logic [WIDTH-1:0] q_next;

    function automatic logic [WIDTH-1:0] next_state(
        input logic [WIDTH-1:0] q,
        input logic             en,
        input logic [1:0]       mode,
        input logic             rot,
        input logic             sin,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH-1:0] nxt;
        nxt = q;
        if (en) begin
            case (mode)
                MODE_RIGHT: nxt = {(rot ? q[0] : sin), q[WIDTH-1:1]};
                MODE_LEFT:  nxt = {q[WIDTH-2:0], (rot ? q[WIDTH-1] : sin)};
                MODE_LOAD:  nxt = d;
                default:    nxt = q;
            endcase
        end
        return nxt;
    endfunction

    always_comb begin
        q_next = next_state(q_p0, bus.input_switch3_en_3, bus.input_switch4_mode_4,
                            bus.input_switch5_rot_5, bus.input_switch6_sin_6,
                            bus.input_switch7_d_7);
    end

    // Stage p0: the flip-flop bank itself
    always_ff @(posedge input_clock1_clk_1 or posedge input_push_button2_rst_2) begin
        if (input_push_button2_rst_2) begin
            q_p0 <= RESET_VALUE;
        end else begin
            q_p0 <= q_next;
        end
    end

    assign bus.output_led1_q_8     = q_p0;
    assign bus.output_led2_qbar_9  = ~q_p0;
    // sout tracks the current mode, not the mode sampled at the last edge
    assign bus.output_led3_sout_10 = (bus.input_switch4_mode_4 == MODE_RIGHT) ? q_p0[0]
                                                                               : q_p0[WIDTH-1];
    assign bus.output_led4_zero_11 = (q_p0 == '0);

    logic unused_hold;
    assign unused_hold = (MODE_HOLD == 2'b00);
endmodule

// File: tb/tb_dflipflop_universal_register.sv
// Bench for the universal register: vector table, hand-written reset/width sequences,
// and randomized traffic against an arithmetic reference model.
module tb_dflipflop_universal_register;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    dflipflop_universal_register_if #(.WIDTH(4)) bus4 ();
    dflipflop_universal_register_if #(.WIDTH(8)) bus8 ();

    dflipflop_universal_register #(.WIDTH(4), .RESET_VALUE(4'b1010)) dut4 (
        .input_clock1_clk_1       (clk),
        .input_push_button2_rst_2 (rst),
        .bus                      (bus4.slave)
    );

    dflipflop_universal_register #(.WIDTH(8), .RESET_VALUE(8'h00)) dut8 (
        .input_clock1_clk_1       (clk),
        .input_push_button2_rst_2 (rst),
        .bus                      (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic       rot;
        logic       sin;
        logic [3:0] d;
        logic [3:0] q;
        logic       sout;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: shifts expressed as integer divide/multiply on the register value.
    function automatic logic [7:0] model_next(input int w, input logic [7:0] q, input logic en,
                                              input logic [1:0] mode, input logic rot,
                                              input logic sin, input logic [7:0] d);
        int qi, fill, mask, r;
        qi   = int'(q);
        mask = (1 << w) - 1;
        r    = qi;
        if (en) begin
            if (mode == 2'd1) begin
                fill = rot ? (qi % 2) : int'(sin);
                r    = (qi / 2) + fill * (1 << (w - 1));
            end else if (mode == 2'd2) begin
                fill = rot ? ((qi / (1 << (w - 1))) % 2) : int'(sin);
                r    = ((qi * 2) + fill) & mask;
            end else if (mode == 2'd3) begin
                r    = int'(d) & mask;
            end
        end
        return 8'(r);
    endfunction

    function automatic logic model_sout(input int w, input logic [7:0] q, input logic [1:0] mode);
        int qi;
        qi = int'(q);
        if (mode == 2'd1) return logic'(qi % 2);
        return logic'((qi / (1 << (w - 1))) % 2);
    endfunction

    task automatic check4(input string name, input logic [3:0] exp_q, input logic exp_sout);
        check({name, ".q"},    {4'h0, bus4.output_led1_q_8},     {4'h0, exp_q});
        check({name, ".qbar"}, {4'h0, bus4.output_led2_qbar_9},  {4'h0, ~exp_q});
        check({name, ".sout"}, {7'h0, bus4.output_led3_sout_10}, {7'h0, exp_sout});
        check({name, ".zero"}, {7'h0, bus4.output_led4_zero_11}, {7'h0, exp_q == 4'h0});
    endtask

    task automatic check8(input string name, input logic [7:0] exp_q, input logic exp_sout);
        check({name, ".q8"},    bus8.output_led1_q_8,             exp_q);
        check({name, ".qbar8"}, bus8.output_led2_qbar_9,          ~exp_q);
        check({name, ".sout8"}, {7'h0, bus8.output_led3_sout_10}, {7'h0, exp_sout});
        check({name, ".zero8"}, {7'h0, bus8.output_led4_zero_11}, {7'h0, exp_q == 8'h00});
    endtask

    task automatic drive4(input logic en, input logic [1:0] mode, input logic rot,
                          input logic sin, input logic [3:0] d);
        bus4.input_switch3_en_3   = en;
        bus4.input_switch4_mode_4 = mode;
        bus4.input_switch5_rot_5  = rot;
        bus4.input_switch6_sin_6  = sin;
        bus4.input_switch7_d_7    = d;
    endtask

    task automatic drive8(input logic en, input logic [1:0] mode, input logic rot,
                          input logic sin, input logic [7:0] d);
        bus8.input_switch3_en_3   = en;
        bus8.input_switch4_mode_4 = mode;
        bus8.input_switch5_rot_5  = rot;
        bus8.input_switch6_sin_6  = sin;
        bus8.input_switch7_d_7    = d;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] m4, m8;
        logic       en, rot, sin;
        logic [1:0] mode;
        logic [7:0] d;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        // Parallel load pending on both, to show reset wins over the edge
        drive4(1'b1, 2'b11, 1'b0, 1'b0, 4'b0110);
        drive8(1'b1, 2'b11, 1'b0, 1'b0, 8'hFF);

        vecs[0]  = '{1'b1, 2'b11, 1'b0, 1'b0, 4'b0110, 4'b0110, 1'b0};
        vecs[1]  = '{1'b1, 2'b00, 1'b0, 1'b0, 4'b0000, 4'b0110, 1'b0};
        vecs[2]  = '{1'b1, 2'b00, 1'b1, 1'b1, 4'b1111, 4'b0110, 1'b0};
        vecs[3]  = '{1'b1, 2'b00, 1'b0, 1'b1, 4'b0000, 4'b0110, 1'b0};
        vecs[4]  = '{1'b0, 2'b11, 1'b0, 1'b0, 4'b1111, 4'b0110, 1'b0};
        vecs[5]  = '{1'b1, 2'b11, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};
        vecs[6]  = '{1'b1, 2'b01, 1'b0, 1'b1, 4'b0000, 4'b1000, 1'b0};
        vecs[7]  = '{1'b1, 2'b01, 1'b0, 1'b1, 4'b0000, 4'b1100, 1'b0};
        vecs[8]  = '{1'b1, 2'b01, 1'b0, 1'b1, 4'b0000, 4'b1110, 1'b0};
        vecs[9]  = '{1'b1, 2'b01, 1'b0, 1'b1, 4'b0000, 4'b1111, 1'b1};
        vecs[10] = '{1'b1, 2'b11, 1'b0, 1'b0, 4'b1001, 4'b1001, 1'b1};
        vecs[11] = '{1'b1, 2'b10, 1'b1, 1'b0, 4'b0000, 4'b0011, 1'b0};
        vecs[12] = '{1'b1, 2'b10, 1'b1, 1'b1, 4'b0000, 4'b0110, 1'b0};
        vecs[13] = '{1'b1, 2'b10, 1'b1, 1'b0, 4'b0000, 4'b1100, 1'b1};
        vecs[14] = '{1'b1, 2'b10, 1'b1, 1'b1, 4'b0000, 4'b1001, 1'b1};

        // Reset pulse between edges: outputs must follow immediately
        #2 rst = 1'b1;
        #1;
        check4("rst_async", 4'b1010, 1'b1);
        check8("rst_async", 8'h00, 1'b0);
        edge_step();
        check4("rst_over_edge", 4'b1010, 1'b1);
        check8("rst_over_edge", 8'h00, 1'b0);
        rst = 1'b0;
        drive8(1'b0, 2'b00, 1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 15; i++) begin
            drive4(vecs[i].en, vecs[i].mode, vecs[i].rot, vecs[i].sin, vecs[i].d);
            edge_step();
            check4($sformatf("vec%0d", i), vecs[i].q, vecs[i].sout);
        end

        // Reset in the middle of a rotate-right sequence, then resume with zero fill
        drive4(1'b1, 2'b11, 1'b0, 1'b0, 4'b0011);
        edge_step();
        check4("mid_load", 4'b0011, 1'b0);
        drive4(1'b1, 2'b01, 1'b1, 1'b0, 4'b0000);
        edge_step();
        check4("mid_rot", 4'b1001, 1'b1);
        #2 rst = 1'b1;
        #1;
        check4("mid_rst", 4'b1010, 1'b0);
        drive4(1'b1, 2'b01, 1'b0, 1'b0, 4'b0000);
        #1 rst = 1'b0;
        edge_step();
        check4("post_rst_shift", 4'b0101, 1'b1);

        // Width 8: zero flag across load and a single zero-fill shift
        check8("w8_idle", 8'h00, 1'b0);
        drive8(1'b1, 2'b11, 1'b0, 1'b0, 8'h01);
        edge_step();
        check8("w8_load", 8'h01, 1'b0);
        drive8(1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
        edge_step();
        check8("w8_shift", 8'h00, 1'b0);

        // Randomized traffic on both widths with occasional async reset pulses
        m4 = {4'h0, bus4.output_led1_q_8};
        m8 = bus8.output_led1_q_8;
        for (int n = 0; n < 300; n++) begin
            en   = ($urandom_range(0, 7) != 0);
            mode = 2'($urandom_range(0, 3));
            rot  = 1'($urandom_range(0, 1));
            sin  = 1'($urandom_range(0, 1));
            d    = 8'($urandom_range(0, 255));
            drive4(en, mode, rot, sin, d[3:0]);
            drive8(en, mode, ~rot, ~sin, ~d);
            if ($urandom_range(0, 31) == 0) begin
                #2 rst = 1'b1;
                #1;
                m4 = 8'h0A;
                m8 = 8'h00;
                check4("rnd_rst", m4[3:0], model_sout(4, m4, mode));
                check8("rnd_rst", m8, model_sout(8, m8, mode));
                rst = 1'b0;
            end
            m4 = model_next(4, m4, en, mode, rot, sin, {4'h0, d[3:0]});
            m8 = model_next(8, m8, en, mode, ~rot, ~sin, ~d);
            edge_step();
            check4("rnd", m4[3:0], model_sout(4, m4, mode));
            check8("rnd", m8, model_sout(8, m8, mode));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
